fifo_burst_reader: RTL and testbench



---
 rtl/fifo_burst_reader.sv | 170 +++++++++++++++++
 tb/tb_fifo_burst_reader.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: read-side consumer for the 12-bit async FIFO IP.
// Issues fifo_rd_en under a 4-entry credit scheme. It captures fifo_rd_data
// RD_LATENCY cycles later into an output buffer. Words leave as fixed-length
// sof/eof bursts on a valid/ready stream. Residual words below the
// almost_empty threshold are flushed as single-word bursts after TIMEOUT
// idle cycles.
// Optional: define FIFO_BURST_READER_PATCHK_EN to add the pat_err output.
// pat_err is a sticky checker for the FIFO bench's descending-count pattern.
module fifo_burst_reader #(
  parameter int DATA_WIDTH = 12,
  parameter int RD_LATENCY = 1,
  parameter int BURST_LEN  = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                  fifo_rd_empty,
  input  logic                  fifo_almost_empty,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_sof,
  output logic                  m_eof,
  output logic                  busy
`ifdef FIFO_BURST_READER_PATCHK_EN
  ,
  output logic                  pat_err
`endif
);

  localparam int BCW = $clog2(BURST_LEN) + 1;
  localparam logic [BCW-1:0] BLAST = BCW'(BURST_LEN - 1);
  localparam logic [15:0]    TLAST = 16'(TIMEOUT - 1);
  localparam logic [15:0]    TSAT  = 16'(TIMEOUT);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BURST = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  sof;
    logic                  eof;
  } ent_t;

  logic [1:0]          state;
  logic [BCW-1:0]      bcnt;
  logic [15:0]         tcnt;
  logic [RD_LATENCY:1] vld_pipe, sof_pipe, eof_pipe;
  ent_t                buf_q [4];
  logic [1:0]          wptr, rptr;
  logic [2:0]          occ, inflight;
  logic                issue, push, pop, tag_sof, tag_eof;
  ent_t                head;

  // Words already requested but not yet landed in the buffer
  always_comb begin
    inflight = '0;
    for (int i = 1; i <= RD_LATENCY; i++) inflight = inflight + 3'(vld_pipe[i]);
  end

  // Credit: buffer slots plus in-flight reads never exceed 4, so the buffer cannot overflow
  assign issue = !rd_rst && (state == S_BURST || state == S_FLUSH) && !fifo_rd_empty
                 && ((occ + inflight) < 3'd4);
  assign fifo_rd_en = issue;
  assign tag_sof    = (state == S_FLUSH) || (bcnt == '0);
  assign tag_eof    = (state == S_FLUSH) || (bcnt == BLAST);
  assign push       = vld_pipe[RD_LATENCY];
  assign pop        = m_valid && m_ready;

  // Issue/tag shift pipeline matching the FIFO read latency
  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      vld_pipe <= '0;
      sof_pipe <= '0;
      eof_pipe <= '0;
    end else begin
      vld_pipe[1] <= issue;
      sof_pipe[1] <= tag_sof;
      eof_pipe[1] <= tag_eof;
      for (int i = 2; i <= RD_LATENCY; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        sof_pipe[i] <= sof_pipe[i-1];
        eof_pipe[i] <= eof_pipe[i-1];
      end
    end
  end

  // Output buffer pointers and occupancy
  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      wptr <= '0;
      rptr <= '0;
      occ  <= '0;
    end else begin
      if (push) wptr <= wptr + 2'd1;
      if (pop)  rptr <= rptr + 2'd1;
      occ <= occ + 3'(push) - 3'(pop);
    end
  end

  // Output buffer storage; contents are don't-care while unoccupied
  always_ff @(posedge rd_clk) begin
    if (push) buf_q[wptr] <= '{data: fifo_rd_data, sof: sof_pipe[RD_LATENCY], eof: eof_pipe[RD_LATENCY]};
  end

  assign head    = buf_q[rptr];
  assign m_valid = (occ != 3'd0);
  assign m_data  = m_valid ? head.data : '0;
  assign m_sof   = m_valid && head.sof;
  assign m_eof   = m_valid && head.eof;
  assign busy    = (state != S_IDLE) || (inflight != 3'd0) || (occ != 3'd0);

  // Burst/flush sequencing with idle timeout
  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      state <= S_IDLE;
      bcnt  <= '0;
      tcnt  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!fifo_almost_empty) begin
            state <= S_BURST;
            bcnt  <= '0;
            tcnt  <= '0;
          end else if (!fifo_rd_empty) begin
            if (tcnt >= TLAST) begin
              state <= S_FLUSH;
              tcnt  <= TSAT;
            end else begin
              tcnt <= tcnt + 16'd1;
            end
          end else begin
            tcnt <= '0;
          end
        end
        S_BURST: begin
          // an empty FIFO stalls the burst, it never shortens it
          if (issue) begin
            bcnt <= bcnt + BCW'(1);
            if (bcnt == BLAST) state <= S_IDLE;
          end
        end
        S_FLUSH: begin
          if (fifo_rd_empty || !fifo_almost_empty) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef FIFO_BURST_READER_PATCHK_EN
  logic [DATA_WIDTH-1:0] pat_exp;

  // Sticky pattern checker; resyncs to received-1 after each accepted word
  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      pat_exp <= '1;
      pat_err <= 1'b0;
    end else if (pop) begin
      if (m_data != pat_exp) pat_err <= 1'b1;
      pat_exp <= m_data - DATA_WIDTH'(1);
    end
  end
`endif

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Self-checking bench for fifo_burst_reader. Two instances share stimulus:
// lane 0 uses RD_LATENCY=1 and lane 1 uses RD_LATENCY=2. Each lane has its
// own behavioural FIFO model. Expected streams come from the burst rule:
// full groups of 4 become bursts, and the remainder becomes single-word bursts.
module tb_fifo_burst_reader;
  logic rd_clk = 1'b0;
  logic rd_rst = 1'b1;
  logic fifo_rst = 1'b1;
  logic m_ready = 1'b0;
  always #5 rd_clk = ~rd_clk;

  logic [1:0]  rd_en, empty, ae, m_valid, sof, eof, busy;
  logic [11:0] rdd [2];
  logic [11:0] mdat [2];
`ifdef FIFO_BURST_READER_PATCHK_EN
  logic [1:0]  pat_err;
`endif

  // FIFO model: memory written by the stimulus process, read pointer owned by the clocked model
  logic [11:0] fmem [2][2048];
  int          wptr [2] = '{0, 0};
  int          rptr [2] = '{0, 0};
  logic [11:0] d1 [2], d2 [2];
  int          ufl = 0;
  int          cyc = 0;

  logic [13:0] got [2][2048];
  int gcnt [2], nrd [2], first_rd [2], last_rd [2], last_acc [2], max_gap [2];
  int total = 0, passed = 0;

  assign empty[0] = (wptr[0] == rptr[0]);
  assign empty[1] = (wptr[1] == rptr[1]);
  assign ae[0]    = (wptr[0] - rptr[0]) < 4;
  assign ae[1]    = (wptr[1] - rptr[1]) < 4;
  assign rdd[0]   = d1[0];
  assign rdd[1]   = d2[1];

  fifo_burst_reader #(.DATA_WIDTH(12), .RD_LATENCY(1), .BURST_LEN(4), .TIMEOUT(64)) u_lat1 (
    .rd_clk(rd_clk), .rd_rst(rd_rst), .fifo_rd_en(rd_en[0]), .fifo_rd_data(rdd[0]),
    .fifo_rd_empty(empty[0]), .fifo_almost_empty(ae[0]), .m_data(mdat[0]), .m_valid(m_valid[0]),
    .m_ready(m_ready), .m_sof(sof[0]), .m_eof(eof[0]), .busy(busy[0])
`ifdef FIFO_BURST_READER_PATCHK_EN
    , .pat_err(pat_err[0])
`endif
  );

  fifo_burst_reader #(.DATA_WIDTH(12), .RD_LATENCY(2), .BURST_LEN(4), .TIMEOUT(64)) u_lat2 (
    .rd_clk(rd_clk), .rd_rst(rd_rst), .fifo_rd_en(rd_en[1]), .fifo_rd_data(rdd[1]),
    .fifo_rd_empty(empty[1]), .fifo_almost_empty(ae[1]), .m_data(mdat[1]), .m_valid(m_valid[1]),
    .m_ready(m_ready), .m_sof(sof[1]), .m_eof(eof[1]), .busy(busy[1])
`ifdef FIFO_BURST_READER_PATCHK_EN
    , .pat_err(pat_err[1])
`endif
  );

  // FIFO read model and stream/strobe monitor
  always @(posedge rd_clk) begin
    cyc <= cyc + 1;
    for (int k = 0; k < 2; k++) begin
      if (fifo_rst) rptr[k] <= wptr[k];
      else if (rd_en[k]) begin
        if (wptr[k] == rptr[k]) ufl <= ufl + 1;
        d1[k]   <= fmem[k][rptr[k] % 2048];
        rptr[k] <= rptr[k] + 1;
      end
      d2[k] <= d1[k];
      if (rd_rst) begin
        gcnt[k] <= 0; nrd[k] <= 0; max_gap[k] <= 0;
      end else begin
        if (rd_en[k]) begin
          if (nrd[k] == 0) first_rd[k] <= cyc;
          last_rd[k] <= cyc;
          nrd[k]     <= nrd[k] + 1;
        end
        if (m_valid[k] && m_ready) begin
          if (gcnt[k] < 2048) got[k][gcnt[k]] <= {mdat[k], sof[k], eof[k]};
          if (gcnt[k] > 0 && (cyc - last_acc[k]) > max_gap[k]) max_gap[k] <= cyc - last_acc[k];
          last_acc[k] <= cyc;
          gcnt[k]     <= gcnt[k] + 1;
        end
      end
    end
  end

  // Reference: word i of n loaded words, descending from FFF
  function automatic logic [13:0] exp_word(int i, int n);
    logic [11:0] d;
    int full;
    d = 12'hFFF - 12'(i);
    full = (n / 4) * 4;
    if (i < full) return {d, (i % 4) == 0, (i % 4) == 3};
    return {d, 1'b1, 1'b1};
  endfunction

  task automatic tick(int n);
    repeat (n) @(negedge rd_clk);
  endtask

  task automatic push(logic [11:0] w);
    for (int k = 0; k < 2; k++) begin
      fmem[k][wptr[k] % 2048] = w;
      wptr[k] = wptr[k] + 1;
    end
  endtask

  task automatic load_desc(int n);
    for (int i = 0; i < n; i++) push(12'hFFF - 12'(i));
  endtask

  task automatic do_reset();
    @(negedge rd_clk);
    rd_rst = 1'b1; fifo_rst = 1'b1; m_ready = 1'b0;
    tick(3);
    rd_rst = 1'b0; fifo_rst = 1'b0;
  endtask

  task automatic wait_words(int n, int budget, bit rnd, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      tick(1);
      if (rnd) m_ready = ($urandom_range(0, 3) != 0);
      if (gcnt[0] >= n && gcnt[1] >= n) begin ok = 1'b1; break; end
    end
    m_ready = 1'b1;
  endtask

  task automatic test_reset();
    fifo_rst = 1'b0; rd_rst = 1'b1; m_ready = 1'b1;
    load_desc(10);
    for (int c = 0; c < 5; c++) begin
      tick(1);
      for (int k = 0; k < 2; k++) begin
        total++; if (rd_en[k] !== 1'b0) $display("FAIL rst_rd_en lane%0d cyc%0d: got %b expected 0", k, c, rd_en[k]); else passed++;
        total++; if (m_valid[k] !== 1'b0) $display("FAIL rst_m_valid lane%0d cyc%0d: got %b expected 0", k, c, m_valid[k]); else passed++;
        total++; if (busy[k] !== 1'b0) $display("FAIL rst_busy lane%0d cyc%0d: got %b expected 0", k, c, busy[k]); else passed++;
      end
    end
    for (int k = 0; k < 2; k++) begin
      total++; if ({mdat[k], sof[k], eof[k]} !== 14'd0) $display("FAIL rst_outputs lane%0d: got %h expected 0", k, {mdat[k], sof[k], eof[k]}); else passed++;
    end
  endtask

  task automatic test_normal_burst();
    do_reset(); m_ready = 1'b1;
    load_desc(5);
    tick(15);
    for (int k = 0; k < 2; k++) begin
      total++; if (nrd[k] !== 4) $display("FAIL burst_rd_count lane%0d: got %0d expected 4", k, nrd[k]); else passed++;
      total++; if (last_rd[k] - first_rd[k] !== 3) $display("FAIL burst_rd_span lane%0d: got %0d expected 3", k, last_rd[k] - first_rd[k]); else passed++;
      total++; if (gcnt[k] !== 4) $display("FAIL burst_words lane%0d: got %0d expected 4", k, gcnt[k]); else passed++;
      total++; if (wptr[k] - rptr[k] !== 1) $display("FAIL burst_left lane%0d: got %0d expected 1", k, wptr[k] - rptr[k]); else passed++;
      for (int i = 0; i < 4; i++) begin
        total++; if (got[k][i] !== exp_word(i, 5)) $display("FAIL burst_word lane%0d idx%0d: got %h expected %h", k, i, got[k][i], exp_word(i, 5)); else passed++;
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    do_reset(); m_ready = 1'b0;
    load_desc(8);
    tick(20);
    for (int k = 0; k < 2; k++) begin
      total++; if (nrd[k] !== 4) $display("FAIL bp_rd_count lane%0d: got %0d expected 4", k, nrd[k]); else passed++;
      total++; if ({m_valid[k], mdat[k], sof[k]} !== {1'b1, 12'hFFF, 1'b1}) $display("FAIL bp_head lane%0d: got %h expected %h", k, {m_valid[k], mdat[k], sof[k]}, {1'b1, 12'hFFF, 1'b1}); else passed++;
    end
    m_ready = 1'b1;
    wait_words(8, 100, 1'b0, ok);
    total++; if (!ok) $display("FAIL bp_drain: got %0d/%0d words expected 8", gcnt[0], gcnt[1]); else passed++;
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 8; i++) begin
        total++; if (got[k][i] !== exp_word(i, 8)) $display("FAIL bp_word lane%0d idx%0d: got %h expected %h", k, i, got[k][i], exp_word(i, 8)); else passed++;
      end
  endtask

  task automatic test_timeout();
    bit ok;
    do_reset(); m_ready = 1'b1;
    load_desc(3);
    tick(63);
    for (int k = 0; k < 2; k++) begin
      total++; if ({nrd[k] == 0, rd_en[k]} !== 2'b10) $display("FAIL to_early lane%0d: got nrd=%0d rd_en=%b expected 0/0", k, nrd[k], rd_en[k]); else passed++;
    end
    tick(1);
    for (int k = 0; k < 2; k++) begin
      total++; if ({nrd[k] == 0, rd_en[k]} !== 2'b11) $display("FAIL to_start lane%0d: got nrd=%0d rd_en=%b expected 0/1", k, nrd[k], rd_en[k]); else passed++;
    end
    wait_words(3, 50, 1'b0, ok);
    total++; if (!ok) $display("FAIL to_drain: got %0d/%0d words expected 3", gcnt[0], gcnt[1]); else passed++;
    tick(5);
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 3; i++) begin
        total++; if (got[k][i] !== exp_word(i, 3)) $display("FAIL to_word lane%0d idx%0d: got %h expected %h", k, i, got[k][i], exp_word(i, 3)); else passed++;
      end
      total++; if (busy[k] !== 1'b0) $display("FAIL to_idle lane%0d: got busy=%b expected 0", k, busy[k]); else passed++;
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int neof;
    do_reset(); m_ready = 1'b1;
    load_desc(1024);
    wait_words(1024, 2000, 1'b0, ok);
    total++; if (!ok) $display("FAIL b2b_drain: got %0d/%0d words expected 1024", gcnt[0], gcnt[1]); else passed++;
    for (int k = 0; k < 2; k++) begin
      neof = 0;
      for (int i = 0; i < 1024; i++) begin
        neof += int'(got[k][i][0]);
        total++; if (got[k][i] !== exp_word(i, 1024)) $display("FAIL b2b_word lane%0d idx%0d: got %h expected %h", k, i, got[k][i], exp_word(i, 1024)); else passed++;
      end
      total++; if (neof !== 256) $display("FAIL b2b_bursts lane%0d: got %0d expected 256", k, neof); else passed++;
      total++; if (got[k][1023] !== {12'hC00, 2'b01}) $display("FAIL b2b_last lane%0d: got %h expected %h", k, got[k][1023], {12'hC00, 2'b01}); else passed++;
      total++; if (max_gap[k] > 2) $display("FAIL b2b_gap lane%0d: got %0d expected <=2", k, max_gap[k]); else passed++;
    end
  endtask

  task automatic test_mid_reset();
    bit ok;
    int c;
    do_reset(); m_ready = 1'b1;
    load_desc(8);
    c = 0;
    while (nrd[0] < 2 && c < 20) begin tick(1); c++; end
    total++; if (nrd[0] < 2) $display("FAIL mid_wait: got %0d issues expected 2", nrd[0]); else passed++;
    rd_rst = 1'b1; fifo_rst = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      total++; if (rd_en[k] !== 1'b0) $display("FAIL mid_rd_en lane%0d: got %b expected 0", k, rd_en[k]); else passed++;
    end
    tick(1);
    for (int k = 0; k < 2; k++) begin
      total++; if ({m_valid[k], busy[k]} !== 2'b00) $display("FAIL mid_flush lane%0d: got %b expected 00", k, {m_valid[k], busy[k]}); else passed++;
    end
    tick(1);
    rd_rst = 1'b0; fifo_rst = 1'b0;
    load_desc(4);
    wait_words(4, 40, 1'b0, ok);
    total++; if (!ok) $display("FAIL mid_drain: got %0d/%0d words expected 4", gcnt[0], gcnt[1]); else passed++;
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 4; i++) begin
        total++; if (got[k][i] !== exp_word(i, 4)) $display("FAIL mid_word lane%0d idx%0d: got %h expected %h", k, i, got[k][i], exp_word(i, 4)); else passed++;
      end
`ifdef FIFO_BURST_READER_PATCHK_EN
    for (int k = 0; k < 2; k++) begin
      total++; if (pat_err[k] !== 1'b0) $display("FAIL pat_clean lane%0d: got %b expected 0", k, pat_err[k]); else passed++;
    end
    do_reset(); m_ready = 1'b1;
    push(12'hFFF); push(12'h123); push(12'h122); push(12'h121);
    wait_words(4, 40, 1'b0, ok);
    for (int k = 0; k < 2; k++) begin
      total++; if (pat_err[k] !== 1'b1) $display("FAIL pat_inject lane%0d: got %b expected 1", k, pat_err[k]); else passed++;
    end
`endif
  endtask

  task automatic test_random();
    bit ok;
    int n;
    for (int it = 0; it < 4; it++) begin
      n = $urandom_range(1, 40);
      do_reset();
      load_desc(n);
      wait_words(n, 4000, 1'b1, ok);
      total++; if (!ok) $display("FAIL rnd_drain it%0d: got %0d/%0d words expected %0d", it, gcnt[0], gcnt[1], n); else passed++;
      for (int k = 0; k < 2; k++)
        for (int i = 0; i < n; i++) begin
          total++; if (got[k][i] !== exp_word(i, n)) $display("FAIL rnd_word it%0d lane%0d idx%0d: got %h expected %h", it, k, i, got[k][i], exp_word(i, n)); else passed++;
        end
    end
  endtask

  initial begin
    test_reset();
    test_normal_burst();
    test_backpressure();
    test_timeout();
    test_back_to_back();
    test_mid_reset();
    test_random();
    total++; if (ufl !== 0) $display("FAIL underflow: got %0d reads while empty expected 0", ufl); else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
